// File: rtl/segment_swapchain_pkg.sv
// Shared types for the segment swap controller: transition modes and FSM states.
package segment_swapchain_pkg;

  typedef enum logic [7:0] {
    TRANSITION_MODE_SYNC_IDX  = 8'h00,
    TRANSITION_MODE_SYS_TIME  = 8'h01,
    TRANSITION_MODE_GPIO      = 8'h02,
    TRANSITION_MODE_EXT       = 8'hF0,
    TRANSITION_MODE_IMMEDIATE = 8'hFF
  } transition_mode_t;

  typedef enum logic [1:0] {
    RUN,
    WAIT_TRIG,
    STOPPED
  } swapchain_state_t;

  function automatic logic mode_known(logic [7:0] mode);
    case (mode)
      TRANSITION_MODE_SYNC_IDX,
      TRANSITION_MODE_SYS_TIME,
      TRANSITION_MODE_GPIO,
      TRANSITION_MODE_EXT,
      TRANSITION_MODE_IMMEDIATE: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/segment_swapchain_trigger.sv
// Trigger evaluation for a pending segment swap: GPIO edge detect plus mode-selected compare.
module swapchain_trigger
  import segment_swapchain_pkg::*;
#(
  parameter int NumGpio      = 4,
  parameter int SysTimeWidth = 56
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [7:0]              mode_i,
  input  logic [63:0]             value_i,
  input  logic [SysTimeWidth-1:0] sys_time_i,
  input  logic [NumGpio-1:0]      gpio_i,
  input  logic                    idx_wrap_i,
  output logic                    fire_o
);

  localparam int GpioIdxW = (NumGpio > 1) ? $clog2(NumGpio) : 1;

  logic [NumGpio-1:0]  gpio_q;
  logic [GpioIdxW-1:0] gpio_sel;
  logic                unused_value;

  // Sampled every cycle so a level already high when a request is latched never counts as an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gpio_q <= '0;
    end else begin
      gpio_q <= gpio_i;
    end
  end

  assign gpio_sel     = value_i[GpioIdxW-1:0];
  assign unused_value = ^value_i;

  always_comb begin
    fire_o = 1'b0;
    case (mode_i)
      TRANSITION_MODE_SYNC_IDX,
      TRANSITION_MODE_EXT:      fire_o = idx_wrap_i;
      TRANSITION_MODE_SYS_TIME: fire_o = (sys_time_i >= value_i[SysTimeWidth-1:0]);
      TRANSITION_MODE_GPIO:     fire_o = gpio_i[gpio_sel] & ~gpio_q[gpio_sel];
      default:                  fire_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/segment_swapchain.sv
// Segment swap controller: request latch, trigger wait, repeat counting and EXT auto-advance.
module segment_swapchain
  import segment_swapchain_pkg::*;
#(
  parameter int  NumSegment   = 2,
  parameter int  RepWidth     = 16,
  parameter int  NumGpio      = 4,
  parameter int  SysTimeWidth = 56,
  localparam int SegW         = $clog2(NumSegment)
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    REQ_VALID,
  input  logic [SegW-1:0]         REQ_SEGMENT,
  input  logic [RepWidth-1:0]     REQ_REP,
  input  logic [7:0]              REQ_TRANSITION_MODE,
  input  logic [63:0]             REQ_TRANSITION_VALUE,
  input  logic [SysTimeWidth-1:0] SYS_TIME,
  input  logic [NumGpio-1:0]      GPIO_IN,
  input  logic                    IDX_WRAP,
  output logic [SegW-1:0]         SEGMENT,
  output logic                    UPDATE,
  output logic                    STOP,
  output logic                    BUSY,
  output logic                    ERR
);

  localparam logic [RepWidth:0] CntOne  = (RepWidth+1)'(1);
  localparam logic [SegW-1:0]   SegOne  = SegW'(1);
  localparam logic [SegW-1:0]   SegLast = SegW'(NumSegment - 1);

  swapchain_state_t    state_q;
  logic [SegW-1:0]     seg_q, pend_seg_q, next_seg;
  logic [RepWidth-1:0] rep_q, pend_rep_q;
  logic [7:0]          mode_q, pend_mode_q;
  logic [63:0]         pend_val_q;
  logic [RepWidth:0]   cnt_q, cnt_inc;
  logic                update_q, stop_q, busy_q, err_q;
  logic                seg_ok, req_ok, fire, rep_inf, count_en, wrap_done;

  swapchain_trigger #(
    .NumGpio      (NumGpio),
    .SysTimeWidth (SysTimeWidth)
  ) u_trigger (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .mode_i     (pend_mode_q),
    .value_i    (pend_val_q),
    .sys_time_i (SYS_TIME),
    .gpio_i     (GPIO_IN),
    .idx_wrap_i (IDX_WRAP),
    .fire_o     (fire)
  );

  always_comb begin
    seg_ok = 1'b0;
    for (int i = 0; i < NumSegment; i++) begin
      if (REQ_SEGMENT == SegW'(i)) seg_ok = 1'b1;
    end
  end

  assign req_ok    = seg_ok && mode_known(REQ_TRANSITION_MODE);
  assign rep_inf   = &rep_q;
  assign count_en  = IDX_WRAP && !rep_inf && !stop_q && (state_q != STOPPED);
  assign cnt_inc   = cnt_q + CntOne;
  assign wrap_done = (cnt_inc == ({1'b0, rep_q} + CntOne));
  assign next_seg  = (seg_q == SegLast) ? '0 : seg_q + SegOne;

  // A valid request always wins; otherwise a trigger commit swallows any same-cycle wrap.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= RUN;
      seg_q       <= '0;
      rep_q       <= '1;
      mode_q      <= TRANSITION_MODE_SYNC_IDX;
      cnt_q       <= '0;
      pend_seg_q  <= '0;
      pend_rep_q  <= '1;
      pend_mode_q <= TRANSITION_MODE_SYNC_IDX;
      pend_val_q  <= '0;
      update_q    <= 1'b0;
      stop_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      update_q <= 1'b0;
      err_q    <= 1'b0;
      if (REQ_VALID && req_ok) begin
        if (REQ_TRANSITION_MODE == TRANSITION_MODE_IMMEDIATE) begin
          seg_q    <= REQ_SEGMENT;
          rep_q    <= REQ_REP;
          mode_q   <= REQ_TRANSITION_MODE;
          cnt_q    <= '0;
          stop_q   <= 1'b0;
          busy_q   <= 1'b0;
          update_q <= 1'b1;
          state_q  <= RUN;
        end else begin
          pend_seg_q  <= REQ_SEGMENT;
          pend_rep_q  <= REQ_REP;
          pend_mode_q <= REQ_TRANSITION_MODE;
          pend_val_q  <= REQ_TRANSITION_VALUE;
          busy_q      <= 1'b1;
          state_q     <= WAIT_TRIG;
        end
      end else begin
        err_q <= REQ_VALID;
        if (state_q == WAIT_TRIG && fire) begin
          seg_q    <= pend_seg_q;
          rep_q    <= pend_rep_q;
          mode_q   <= pend_mode_q;
          cnt_q    <= '0;
          stop_q   <= 1'b0;
          busy_q   <= 1'b0;
          update_q <= 1'b1;
          state_q  <= RUN;
        end else if (count_en) begin
          if (!wrap_done) begin
            cnt_q <= cnt_inc;
          end else if (state_q == RUN && mode_q == TRANSITION_MODE_EXT) begin
            seg_q    <= next_seg;
            cnt_q    <= '0;
            update_q <= 1'b1;
          end else begin
            stop_q <= 1'b1;
            if (state_q == RUN) state_q <= STOPPED;
          end
        end
      end
    end
  end

  assign SEGMENT = seg_q;
  assign UPDATE  = update_q;
  assign STOP    = stop_q;
  assign BUSY    = busy_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_segment_swapchain.sv
// Directed and randomized bench for segment_swapchain against a behavioural playback model.
module tb_segment_swapchain;
  import segment_swapchain_pkg::*;

  localparam int NumSeg  = 5;
  localparam int RepW    = 4;
  localparam int NumGpio = 4;
  localparam int SysW    = 56;
  localparam int RepInf  = 15;

  localparam logic [7:0] ModeSync = TRANSITION_MODE_SYNC_IDX;
  localparam logic [7:0] ModeSys  = TRANSITION_MODE_SYS_TIME;
  localparam logic [7:0] ModeGpio = TRANSITION_MODE_GPIO;
  localparam logic [7:0] ModeExt  = TRANSITION_MODE_EXT;
  localparam logic [7:0] ModeImm  = TRANSITION_MODE_IMMEDIATE;

  logic              clk = 1'b0;
  logic              rstN;
  logic              reqValid;
  logic [2:0]        reqSegment;
  logic [RepW-1:0]   reqRep;
  logic [7:0]        reqMode;
  logic [63:0]       reqValue;
  logic [SysW-1:0]   sysTime;
  logic [NumGpio-1:0] gpioIn;
  logic              idxWrap;
  logic [2:0]        segment;
  logic              update, stop, busy, err;

  int errors = 0;
  int checks = 0;

  // Playback model: what segment plays, how many wraps it has had, what is waiting.
  int          mSeg, mRep, mWraps;
  logic [7:0]  mMode;
  bit          mStop, mPend;
  int          pSeg, pRep;
  logic [7:0]  pMode;
  logic [63:0] pVal;
  logic [3:0]  mPrevGpio;
  bit          expUpdate, expErr;

  segment_swapchain #(
    .NumSegment   (NumSeg),
    .RepWidth     (RepW),
    .NumGpio      (NumGpio),
    .SysTimeWidth (SysW)
  ) dut (
    .CLK                  (clk),
    .RST_N                (rstN),
    .REQ_VALID            (reqValid),
    .REQ_SEGMENT          (reqSegment),
    .REQ_REP              (reqRep),
    .REQ_TRANSITION_MODE  (reqMode),
    .REQ_TRANSITION_VALUE (reqValue),
    .SYS_TIME             (sysTime),
    .GPIO_IN              (gpioIn),
    .IDX_WRAP             (idxWrap),
    .SEGMENT              (segment),
    .UPDATE               (update),
    .STOP                 (stop),
    .BUSY                 (busy),
    .ERR                  (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mSeg = 0; mRep = RepInf; mWraps = 0; mMode = ModeSync;
    mStop = 0; mPend = 0; pSeg = 0; pRep = RepInf; pMode = ModeSync; pVal = '0;
    mPrevGpio = '0; expUpdate = 0; expErr = 0;
  endtask

  task automatic modelCommit(input int s, input int r, input logic [7:0] m);
    mSeg = s; mRep = r; mMode = m; mWraps = 0;
    mStop = 0; mPend = 0; expUpdate = 1;
  endtask

  task automatic modelStep();
    bit fire, reqOk;
    expUpdate = 0;
    expErr    = 0;
    reqOk = (int'(reqSegment) < NumSeg) &&
            (reqMode inside {ModeSync, ModeSys, ModeGpio, ModeExt, ModeImm});
    case (pMode)
      ModeSync, ModeExt: fire = idxWrap;
      ModeSys:           fire = (sysTime >= pVal[SysW-1:0]);
      ModeGpio:          fire = gpioIn[pVal[1:0]] && !mPrevGpio[pVal[1:0]];
      default:           fire = 0;
    endcase
    if (reqValid && reqOk) begin
      if (reqMode == ModeImm) begin
        modelCommit(int'(reqSegment), int'(reqRep), reqMode);
      end else begin
        mPend = 1; pSeg = int'(reqSegment); pRep = int'(reqRep);
        pMode = reqMode; pVal = reqValue;
      end
    end else begin
      expErr = reqValid;
      if (mPend && fire) begin
        modelCommit(pSeg, pRep, pMode);
      end else if (idxWrap && !mStop && mRep != RepInf) begin
        mWraps++;
        if (mWraps == mRep + 1) begin
          if (!mPend && mMode == ModeExt) begin
            mSeg = (mSeg + 1) % NumSeg;
            mWraps = 0;
            expUpdate = 1;
          end else begin
            mStop = 1;
          end
        end
      end
    end
    mPrevGpio = gpioIn;
  endtask

  task automatic applyStimulus(input bit valid, input int seg, input int rep,
                               input logic [7:0] mode, input logic [63:0] value, input bit wrap);
    reqValid   = valid;
    reqSegment = 3'(seg);
    reqRep     = RepW'(rep);
    reqMode    = mode;
    reqValue   = value;
    idxWrap    = wrap;
  endtask

  task automatic checkOutput();
    check("segment", 8'(segment), 8'(mSeg));
    check("update", 8'(update), 8'(expUpdate));
    check("stop", 8'(stop), 8'(mStop));
    check("busy", 8'(busy), 8'(mPend));
    check("err", 8'(err), 8'(expErr));
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(0, 0, 0, ModeSync, '0, 0);
      tick();
    end
  endtask

  task automatic wraps(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(0, 0, 0, ModeSync, '0, 1);
      tick();
    end
  endtask

  initial begin
    int r, b;
    rstN    = 1'b0;
    sysTime = '0;
    gpioIn  = '0;
    applyStimulus(0, 0, 0, ModeSync, '0, 0);
    modelReset();
    #2;
    check("rst_segment", 8'(segment), 8'd0);
    check("rst_update", 8'(update), 8'd0);
    check("rst_stop", 8'(stop), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_err", 8'(err), 8'd0);
    @(posedge clk); @(posedge clk); #1;
    rstN = 1'b1;

    $display("[TB] immediate commit and infinite repeat");
    applyStimulus(1, 1, RepInf, ModeImm, '0, 0);
    tick();
    check("imm_segment", 8'(segment), 8'd1);
    check("imm_update", 8'(update), 8'd1);
    idle(1);
    wraps(10);
    check("inf_no_stop", 8'(stop), 8'd0);

    $display("[TB] sync-index swap");
    applyStimulus(1, 0, RepInf, ModeImm, '0, 0);
    tick();
    applyStimulus(1, 1, RepInf, ModeSync, '0, 0);
    tick();
    check("sync_busy", 8'(busy), 8'd1);
    idle(3);
    wraps(1);
    check("sync_segment", 8'(segment), 8'd1);
    check("sync_busy_clr", 8'(busy), 8'd0);

    $display("[TB] system-time swap");
    sysTime = 990;
    applyStimulus(1, 2, RepInf, ModeSys, 64'd1000, 0);
    tick();
    for (int t = 991; t <= 1000; t++) begin
      sysTime = SysW'(t);
      applyStimulus(0, 0, 0, ModeSync, '0, 0);
      tick();
    end
    check("time_segment", 8'(segment), 8'd2);
    check("time_update", 8'(update), 8'd1);
    applyStimulus(1, 3, RepInf, ModeSys, 64'd0, 0);
    tick();
    idle(1);
    check("time_past", 8'(segment), 8'd3);

    $display("[TB] gpio swap");
    gpioIn = 4'b0100;
    idle(1);
    applyStimulus(1, 4, RepInf, ModeGpio, 64'd2, 0);
    tick();
    idle(3);
    check("gpio_hold", 8'(segment), 8'd3);
    gpioIn = 4'b0000;
    idle(1);
    gpioIn = 4'b0100;
    idle(1);
    check("gpio_segment", 8'(segment), 8'd4);

    $display("[TB] ext auto-advance and finite stop");
    applyStimulus(1, 4, 1, ModeExt, '0, 0);
    tick();
    wraps(1);
    check("ext_commit", 8'(segment), 8'd4);
    wraps(2);
    check("ext_adv0", 8'(segment), 8'd0);
    wraps(2);
    check("ext_adv1", 8'(segment), 8'd1);
    applyStimulus(1, 2, 0, ModeImm, '0, 0);
    tick();
    wraps(1);
    check("rep0_stop", 8'(stop), 8'd1);
    wraps(1);
    check("stopped_seg", 8'(segment), 8'd2);

    $display("[TB] rejected and superseded requests");
    applyStimulus(1, 5, 0, ModeSync, '0, 0);
    tick();
    check("bad_seg_err", 8'(err), 8'd1);
    check("bad_seg_keep", 8'(segment), 8'd2);
    applyStimulus(1, 1, 0, 8'h33, '0, 0);
    tick();
    check("bad_mode_err", 8'(err), 8'd1);
    applyStimulus(1, 1, RepInf, ModeSync, '0, 0);
    tick();
    idle(1);
    applyStimulus(1, 3, RepInf, ModeSync, '0, 1);
    tick();
    check("supersede_keep", 8'(segment), 8'd2);
    wraps(1);
    check("supersede_seg", 8'(segment), 8'd3);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 600; n++) begin
      logic [7:0]  mode;
      logic [63:0] value;
      int          rep;
      r = $urandom_range(0, 5);
      case (r)
        0: mode = ModeSync;
        1: mode = ModeSys;
        2: mode = ModeGpio;
        3: mode = ModeExt;
        4: mode = ModeImm;
        default: mode = 8'h33;
      endcase
      rep = $urandom_range(0, 4);
      if (rep == 4) rep = RepInf;
      if (mode == ModeSys) value = 64'(sysTime) + 64'($urandom_range(0, 20)) - 64'd5;
      else if (mode == ModeGpio) value = 64'($urandom_range(0, 3));
      else value = {32'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) == 0) begin
        b = $urandom_range(0, 3);
        gpioIn[b] = ~gpioIn[b];
      end
      sysTime = sysTime + 1'b1;
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 7), rep, mode, value,
                    $urandom_range(0, 3) == 0);
      tick();
    end

    $display("[TB] asynchronous reset with a pending request");
    applyStimulus(1, 2, 1, ModeSync, '0, 0);
    tick();
    #2;
    rstN = 1'b0;
    #1;
    modelReset();
    check("arst_segment", 8'(segment), 8'd0);
    check("arst_busy", 8'(busy), 8'd0);
    check("arst_stop", 8'(stop), 8'd0);
    #2;
    rstN = 1'b1;
    wraps(2);
    check("arst_lost", 8'(segment), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
